// File: rtl/four_bit_counter.sv
// Free-running modulo-(MAX_COUNT+1) counter with terminal-count flag, wrap pulse and saturating wrap tally.
// Count updates on every rising clk edge with no pipeline stage to the port; no backpressure, always advancing.
module four_bit_counter #(
  parameter int WIDTH      = 4,
  parameter int MAX_COUNT  = 2**WIDTH - 1,
  parameter int WRAP_CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [WIDTH-1:0]      count,
  output logic                  tc,
  output logic                  wrap,
  output logic [WRAP_CNT_W-1:0] wrap_cnt
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MAX_COUNT);

  logic at_max;

  assign at_max = (count == MAX_VAL);
  assign tc     = at_max;

  // The wrap tally holds at all-ones while wrap itself keeps pulsing.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count    <= '0;
      wrap     <= 1'b0;
      wrap_cnt <= '0;
    end else if (at_max) begin
      count <= '0;
      wrap  <= 1'b1;
      if (wrap_cnt != {WRAP_CNT_W{1'b1}}) begin
        wrap_cnt <= wrap_cnt + 1'b1;
      end
    end else begin
      count <= count + 1'b1;
      wrap  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_four_bit_counter.sv
// Bench for four_bit_counter: a default 0..15 instance and a MAX_COUNT=9 instance share clock and reset.
`timescale 1ns/100ps
module tb_four_bit_counter;

  logic       clk;
  logic       reset;
  logic [3:0] count16, count10;
  logic       tc16, tc10, wrap16, wrap10;
  logic [7:0] wcnt16, wcnt10;

  int n_total = 0;
  int n_pass  = 0;
  int edges   = 0;

  four_bit_counter dut16 (
    .clk(clk), .reset(reset), .count(count16), .tc(tc16), .wrap(wrap16), .wrap_cnt(wcnt16)
  );

  four_bit_counter #(.WIDTH(4), .MAX_COUNT(9), .WRAP_CNT_W(8)) dut10 (
    .clk(clk), .reset(reset), .count(count10), .tc(tc10), .wrap(wrap10), .wrap_cnt(wcnt10)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: everything follows from the number of edges seen since reset release.
  function automatic int m_count(int e, int m);
    return e % (m + 1);
  endfunction

  function automatic int m_tc(int e, int m);
    return (e % (m + 1)) == m ? 1 : 0;
  endfunction

  function automatic int m_wrap(int e, int m);
    return (e > 0 && (e % (m + 1)) == 0) ? 1 : 0;
  endfunction

  function automatic int m_wcnt(int e, int m);
    int w;
    w = e / (m + 1);
    return (w > 255) ? 255 : w;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input int expv);
    n_total++;
    assert (obs === 32'(expv)) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d edges=%0d t=%0t", tag, obs, expv, edges, $time);
  endtask

  task automatic check_all(input string ph);
    chk({ph, ":count16"}, 32'(count16), m_count(edges, 15));
    chk({ph, ":tc16"},    32'(tc16),    m_tc(edges, 15));
    chk({ph, ":wrap16"},  32'(wrap16),  m_wrap(edges, 15));
    chk({ph, ":wcnt16"},  32'(wcnt16),  m_wcnt(edges, 15));
    chk({ph, ":count10"}, 32'(count10), m_count(edges, 9));
    chk({ph, ":tc10"},    32'(tc10),    m_tc(edges, 9));
    chk({ph, ":wrap10"},  32'(wrap10),  m_wrap(edges, 9));
    chk({ph, ":wcnt10"},  32'(wcnt10),  m_wcnt(edges, 9));
  endtask

  task automatic step(input string ph);
    @(posedge clk);
    if (reset) edges++;
    #1;
    check_all(ph);
  endtask

  // Short reset pulse placed between clock edges; registers must clear without an edge.
  task automatic reset_pulse(input string ph);
    reset = 1'b0;
    edges = 0;
    #0.5;
    check_all(ph);
    #0.5;
    reset = 1'b1;
  endtask

  initial begin
    int n;
    int guard;
    reset = 1'b1;

    // Power-on reset: low at t=2, high at t=3, then count 1..4 after edges 5,15,25,35.
    #2 reset = 1'b0;
    #1 reset = 1'b1;
    #1 check_all("por");
    repeat (4) step("por_run");

    // Mid-count reset at t=43 with count=4, released at t=44.
    #7;
    reset_pulse("mid_rst");
    step("mid_rst_after");

    // Random-length runs interrupted by asynchronous reset pulses.
    repeat (20) begin
      n = $urandom_range(1, 40);
      repeat (n) step("rand_run");
      #1;
      reset_pulse("rand_rst");
      step("rand_after");
    end

    // Reset landing in the wrap cycle of the default instance.
    guard = 0;
    while (!(edges > 0 && (edges % 16) == 0) && guard < 40) begin
      step("to_wrap");
      guard++;
    end
    chk("reach_wrap16", 32'(wrap16), 1);
    #1;
    reset_pulse("wrap_rst");
    step("wrap_rst_after");

    // Reset asserted exactly at a rising edge, then held across several edges.
    repeat ($urandom_range(3, 12)) step("pre_coinc");
    @(posedge clk);
    reset = 1'b0;
    edges = 0;
    #1 check_all("coinc_rst");
    repeat (4) step("held_rst");
    @(negedge clk);
    reset = 1'b1;
    step("held_release");

    // Long free run past wrap_cnt saturation on both instances.
    repeat (256 * 16 + 32) step("long");
    chk("sat_wcnt16", 32'(wcnt16), 255);
    chk("sat_wcnt10", 32'(wcnt10), 255);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
